// File: rtl/bg_fetch_sched_if.sv
// ----------------------------------------------------------------------------
// bg_fetch_sched_if
// Shared PPU memory read port used by the background fetch scheduler.
//   bus_addr  14  PPU address of the current fetch (driven by master)
//   bus_rd     1  read request; data returns on bus_data at next clk_en edge
//   bus_data   8  read data (driven by slave / memory)
// Modports: master = scheduler side, slave = memory side.
// ----------------------------------------------------------------------------
interface bg_fetch_sched_if;
    logic [13:0] bus_addr;
    logic        bus_rd;
    logic [7:0]  bus_data;

    modport master (output bus_addr, output bus_rd, input bus_data);
    modport slave  (input bus_addr, input bus_rd, output bus_data);
endinterface

// File: rtl/bg_fetch_sched.sv
// ----------------------------------------------------------------------------
// bg_fetch_sched
// Background fetch scheduler for the PPU. Owns the shared PPU memory read
// port, sequences NT -> AT -> PT-lo -> PT-hi fetches (one tile per 8 dots),
// emits the vAddr scroll strobes and delivers completed tile records.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   clk_en               PPU dot enable; all state advances only when high
//   render_en            background rendering enabled
//   sl_row, sl_col       current scanline / dot
//   vaddr                {fY, nt, cY, cX}
//   patt_tbl             background pattern table select
//   bus                  memory read port (bg_fetch_sched_if.master)
//   tile_nt/attr/lo/hi   latched tile record
//   tile_valid           pulse: tile record complete
//   h_inc, v_inc         pulses: increment coarse X / fine+coarse Y
//   h_copy, v_copy       pulses: copy horizontal / vertical bits from t
//
// Build option
//   BG_DUMMY_NT_FETCH_EN  when defined, dots 337 and 339 issue discarded
//                         nametable reads (for mappers that count NT reads).
//
// All pulses are registered on the clk_en edge that closes the dot which
// generates them, so they are visible during the following dot.
// ----------------------------------------------------------------------------
module bg_fetch_sched #(
    parameter logic [8:0]  PRERENDER_ROW = 9'h1FF,
    parameter int unsigned VIS_ROWS      = 240
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    render_en,
    input  logic [8:0]              sl_row,
    input  logic [8:0]              sl_col,
    input  logic [14:0]             vaddr,
    input  logic                    patt_tbl,
    bg_fetch_sched_if.master        bus,
    output logic [7:0]              tile_nt,
    output logic [1:0]              tile_attr,
    output logic [7:0]              tile_lo,
    output logic [7:0]              tile_hi,
    output logic                    tile_valid,
    output logic                    h_inc,
    output logic                    v_inc,
    output logic                    h_copy,
    output logic                    v_copy
);

    typedef enum logic [3:0] {
        IDLE, NT_A, NT_D, AT_A, AT_D, LO_A, LO_D, HI_A, HI_D
    } state_t;

    localparam logic [8:0] VIS_ROWS_W = VIS_ROWS[8:0];

    function automatic logic col_in_win(input logic [8:0] c);
        return ((c >= 9'd1) && (c <= 9'd256)) || ((c >= 9'd321) && (c <= 9'd336));
    endfunction

    state_t     state_q, state_d;
    logic [7:0] tile_nt_q, tile_nt_d, tile_lo_q, tile_lo_d, tile_hi_q, tile_hi_d;
    logic [1:0] tile_attr_q, tile_attr_d;
    logic       tile_valid_q, tile_valid_d, h_inc_q, h_inc_d, v_inc_q, v_inc_d;
    logic       h_copy_q, h_copy_d, v_copy_q, v_copy_d;
    logic       row_ok, cur_win, next_win, dummy_rd;
    logic [8:0] next_col;
    logic [1:0] attr_sel;
    logic [13:0] nt_addr, at_addr, lo_addr, hi_addr;

    assign row_ok   = (sl_row < VIS_ROWS_W) || (sl_row == PRERENDER_ROW);
    assign next_col = sl_col + 9'd1;
    assign cur_win  = render_en && row_ok && col_in_win(sl_col);
    // The FSM looks one dot ahead so a fetch state always lines up with
    // the dot it serves; leaving the window drops straight back to IDLE.
    assign next_win = render_en && row_ok && col_in_win(next_col);

    assign nt_addr = 14'h2000 | {2'b00, vaddr[11:0]};
    assign at_addr = 14'h23C0 | {2'b00, vaddr[11:10], 4'b0000, vaddr[9:7], vaddr[4:2]};
    assign lo_addr = {1'b0, patt_tbl, tile_nt_q, 1'b0, vaddr[14:12]};
    assign hi_addr = lo_addr | 14'd8;

    // Quadrant select: shift by {cY[1], cX[1], 0} and keep two bits.
    always_comb begin
        case ({vaddr[6], vaddr[1]})
            2'b00:   attr_sel = bus.bus_data[1:0];
            2'b01:   attr_sel = bus.bus_data[3:2];
            2'b10:   attr_sel = bus.bus_data[5:4];
            default: attr_sel = bus.bus_data[7:6];
        endcase
    end

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch; the defaults mean "hold".
    always_comb begin
        state_d      = state_q;
        tile_nt_d    = tile_nt_q;
        tile_attr_d  = tile_attr_q;
        tile_lo_d    = tile_lo_q;
        tile_hi_d    = tile_hi_q;
        tile_valid_d = 1'b0;
        h_inc_d      = 1'b0;
        v_inc_d      = 1'b0;
        h_copy_d     = 1'b0;
        v_copy_d     = 1'b0;
        if (clk_en) begin
            if (!next_win) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    // Only start on a tile boundary (dots 1, 9, ..., 321, 329)
                    // so tiles stay aligned after a mid-row enable or reset.
                    IDLE:    state_d = (next_col[2:0] == 3'd1) ? NT_A : IDLE;
                    NT_A:    state_d = NT_D;
                    NT_D:    state_d = AT_A;
                    AT_A:    state_d = AT_D;
                    AT_D:    state_d = LO_A;
                    LO_A:    state_d = LO_D;
                    LO_D:    state_d = HI_A;
                    HI_A:    state_d = HI_D;
                    default: state_d = NT_A;
                endcase
            end
            if (cur_win) begin
                case (state_q)
                    NT_D: tile_nt_d   = bus.bus_data;
                    AT_D: tile_attr_d = attr_sel;
                    LO_D: tile_lo_d   = bus.bus_data;
                    HI_D: begin
                        tile_hi_d    = bus.bus_data;
                        tile_valid_d = 1'b1;
                        h_inc_d      = 1'b1;
                    end
                    default: ;
                endcase
            end
            v_inc_d  = render_en && row_ok && (sl_col == 9'd256);
            h_copy_d = render_en && row_ok && (sl_col == 9'd257);
            v_copy_d = render_en && (sl_row == PRERENDER_ROW)
                       && (sl_col >= 9'd280) && (sl_col <= 9'd304);
        end
    end

`ifdef BG_DUMMY_NT_FETCH_EN
    logic dummy_rd_q, dummy_rd_d;

    always_comb begin
        dummy_rd_d = dummy_rd_q;
        if (clk_en) begin
            dummy_rd_d = render_en && row_ok
                         && ((next_col == 9'd337) || (next_col == 9'd339));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dummy_rd_q <= 1'b0;
        else        dummy_rd_q <= dummy_rd_d;
    end

    assign dummy_rd = dummy_rd_q && render_en;
`else
    assign dummy_rd = 1'b0;
`endif

    // Bus outputs decode from the registered state, so reset clears them
    // immediately; the current-dot window gate suppresses the last dot of a
    // fetch when render_en drops.
    always_comb begin
        bus.bus_rd   = 1'b0;
        bus.bus_addr = 14'h0000;
        if (cur_win) begin
            case (state_q)
                NT_A: begin bus.bus_rd = 1'b1; bus.bus_addr = nt_addr; end
                AT_A: begin bus.bus_rd = 1'b1; bus.bus_addr = at_addr; end
                LO_A: begin bus.bus_rd = 1'b1; bus.bus_addr = lo_addr; end
                HI_A: begin bus.bus_rd = 1'b1; bus.bus_addr = hi_addr; end
                default: ;
            endcase
        end
        if (dummy_rd) begin
            bus.bus_rd   = 1'b1;
            bus.bus_addr = nt_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tile_nt_q    <= 8'h00;
            tile_attr_q  <= 2'b00;
            tile_lo_q    <= 8'h00;
            tile_hi_q    <= 8'h00;
            tile_valid_q <= 1'b0;
            h_inc_q      <= 1'b0;
            v_inc_q      <= 1'b0;
            h_copy_q     <= 1'b0;
            v_copy_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_nt_q    <= tile_nt_d;
            tile_attr_q  <= tile_attr_d;
            tile_lo_q    <= tile_lo_d;
            tile_hi_q    <= tile_hi_d;
            tile_valid_q <= tile_valid_d;
            h_inc_q      <= h_inc_d;
            v_inc_q      <= v_inc_d;
            h_copy_q     <= h_copy_d;
            v_copy_q     <= v_copy_d;
        end
    end

    assign tile_nt    = tile_nt_q;
    assign tile_attr  = tile_attr_q;
    assign tile_lo    = tile_lo_q;
    assign tile_hi    = tile_hi_q;
    assign tile_valid = tile_valid_q;
    assign h_inc      = h_inc_q;
    assign v_inc      = v_inc_q;
    assign h_copy     = h_copy_q;
    assign v_copy     = v_copy_q;

endmodule

// File: tb/tb_bg_fetch_sched.sv
// ----------------------------------------------------------------------------
// tb_bg_fetch_sched
// Directed bench for bg_fetch_sched. The bench owns the dot counter
// (sl_row/sl_col advance once per clk_en edge) and a PPU memory model that
// returns read data on the clk_en edge after bus_rd. Outputs are sampled 2
// time units after the active edge, i.e. during the dot that follows the
// edge, so a pulse generated at dot N is observed while sl_col == N+1.
// ----------------------------------------------------------------------------
module tb_bg_fetch_sched;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, render_en, patt_tbl;
    logic [8:0]  sl_row, sl_col;
    logic [14:0] vaddr;
    logic [7:0]  tile_nt, tile_lo, tile_hi;
    logic [1:0]  tile_attr;
    logic        tile_valid, h_inc, v_inc, h_copy, v_copy;
    logic [7:0]  mem [0:16383];

    int tests = 0;
    int fails = 0;

    bg_fetch_sched_if bus_if ();

    bg_fetch_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .render_en  (render_en),
        .sl_row     (sl_row),
        .sl_col     (sl_col),
        .vaddr      (vaddr),
        .patt_tbl   (patt_tbl),
        .bus        (bus_if),
        .tile_nt    (tile_nt),
        .tile_attr  (tile_attr),
        .tile_lo    (tile_lo),
        .tile_hi    (tile_hi),
        .tile_valid (tile_valid),
        .h_inc      (h_inc),
        .v_inc      (v_inc),
        .h_copy     (h_copy),
        .v_copy     (v_copy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clk_en && bus_if.bus_rd) bus_if.bus_data <= mem[bus_if.bus_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one dot.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sl_col == 9'd340) begin
            sl_col = 9'd0;
            if (sl_row == 9'd260)      sl_row = 9'h1FF;
            else if (sl_row == 9'h1FF) sl_row = 9'd0;
            else                       sl_row = sl_row + 9'd1;
        end else begin
            sl_col = sl_col + 9'd1;
        end
        #1;
    endtask

    // Clock edge without advancing the dot (used while clk_en is low).
    task automatic clk_only();
        @(posedge clk);
        #2;
    endtask

    // Force the FSM to IDLE, then jump to dot 0 of a row with rendering on.
    task automatic restart_row(input logic [8:0] row);
        render_en = 1'b0;
        tick();
        sl_row    = row;
        sl_col    = 9'd0;
        render_en = 1'b1;
    endtask

    initial begin
        int n_valid, n_hinc, n_vinc, n_hcopy, n_vcopy;
        logic flag_a, flag_b, rd337, rd339, rd_tail;
        logic [13:0] a337, a339;

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h2000] = 8'h24;
        mem[14'h23C0] = 8'hE4;
        mem[14'h0240] = 8'hF0;
        mem[14'h0248] = 8'h0F;
        mem[14'h24C6] = 8'h5A;
        mem[14'h27C9] = 8'h1B;
        mem[14'h15A3] = 8'h33;
        mem[14'h15AB] = 8'hCC;

        rst_n = 1'b0; clk_en = 1'b1; render_en = 1'b1; patt_tbl = 1'b0;
        sl_row = 9'd0; sl_col = 9'd0; vaddr = 15'h0000;

        // Reset state
        clk_only(); clk_only();
        check("rst_bus_rd", 32'(bus_if.bus_rd), 32'h0);
        check("rst_bus_addr", 32'(bus_if.bus_addr), 32'h0);
        check("rst_tile", {tile_nt, tile_lo, tile_hi, 6'(tile_attr), tile_valid, h_inc},
              32'h0);
        check("rst_strobes", {28'h0, v_inc, h_copy, v_copy, tile_valid}, 32'h0);
        rst_n = 1'b1;

        // Row 0, first tile: fetch address sequence and tile record
        tick();
        check("t0_nt_addr", {bus_if.bus_rd, 17'h0, bus_if.bus_addr}, {1'b1, 17'h0, 14'h2000});
        tick();
        check("t0_nt_d_rd", 32'(bus_if.bus_rd), 32'h0);
        tick();
        check("t0_at_addr", {bus_if.bus_rd, 17'h0, bus_if.bus_addr}, {1'b1, 17'h0, 14'h23C0});
        tick(); tick();
        check("t0_lo_addr", {bus_if.bus_rd, 17'h0, bus_if.bus_addr}, {1'b1, 17'h0, 14'h0240});
        tick(); tick();
        check("t0_hi_addr", {bus_if.bus_rd, 17'h0, bus_if.bus_addr}, {1'b1, 17'h0, 14'h0248});
        tick();
        check("t0_no_valid_early", 32'(tile_valid), 32'h0);
        tick(); // pulse from the edge closing dot 8
        check("t0_valid_hinc", {30'h0, tile_valid, h_inc}, 32'h3);
        check("t0_record", {6'h0, tile_attr, tile_nt, tile_lo, tile_hi}, 32'h0024F00F);
        tick();
        check("t0_valid_single", 32'(tile_valid), 32'h0);

        // Run to the end of row 0, then count a whole row 1
        while (sl_col != 9'd0) tick();
        n_valid = 0; n_hinc = 0; n_vinc = 0; n_hcopy = 0; n_vcopy = 0;
        flag_a = 1'b0; flag_b = 1'b0; rd337 = 1'b0; rd339 = 1'b0; rd_tail = 1'b0;
        a337 = 14'h0; a339 = 14'h0;
        for (int i = 0; i < 341; i++) begin
            tick();
            n_valid += int'(tile_valid);
            n_hinc  += int'(h_inc);
            n_vinc  += int'(v_inc);
            n_hcopy += int'(h_copy);
            n_vcopy += int'(v_copy);
            if (sl_row == 9'd1 && sl_col == 9'd257) flag_a = v_inc & h_inc;
            if (sl_row == 9'd1 && sl_col == 9'd258) flag_b = h_copy;
            if (sl_col >= 9'd257 && sl_col <= 9'd320 && bus_if.bus_rd) rd_tail = 1'b1;
            if (sl_col == 9'd337) begin rd337 = bus_if.bus_rd; a337 = bus_if.bus_addr; end
            if (sl_col == 9'd339) begin rd339 = bus_if.bus_rd; a339 = bus_if.bus_addr; end
            if ((sl_col == 9'd338 || sl_col == 9'd340) && bus_if.bus_rd) rd_tail = 1'b1;
        end
        check("row_tile_valid_cnt", 32'(n_valid), 32'd34);
        check("row_h_inc_cnt", 32'(n_hinc), 32'd34);
        check("row_v_inc_cnt", 32'(n_vinc), 32'd1);
        check("row_h_copy_cnt", 32'(n_hcopy), 32'd1);
        check("row_v_copy_cnt", 32'(n_vcopy), 32'd0);
        check("col256_h_v_together", 32'(flag_a), 32'h1);
        check("col257_h_copy", 32'(flag_b), 32'h1);
        check("no_rd_gap_or_tail", 32'(rd_tail), 32'h0);
`ifdef BG_DUMMY_NT_FETCH_EN
        check("dummy_337", {rd337, 3'h0, a337}, {1'b1, 3'h0, 14'h2000});
        check("dummy_339", {rd339, 3'h0, a339}, {1'b1, 3'h0, 14'h2000});
`else
        check("no_dummy_337", {rd337, 3'h0, a337}, 18'h0);
        check("no_dummy_339", {rd339, 3'h0, a339}, 18'h0);
`endif

        // Attribute quadrant: cX = 2, cY = 0
        vaddr = 15'h0002;
        for (int i = 0; i < 9; i++) tick();
        check("attr_cx2_cy0", 32'(tile_attr), 32'h1);

        // Attribute quadrant: cX = 2, cY = 2
        restart_row(9'd3);
        vaddr = 15'h0042;
        for (int i = 0; i < 9; i++) tick();
        check("attr_cx2_cy2", 32'(tile_attr), 32'h3);

        // Full address composition: fY=3, nt=1, cY=6, cX=6, pattern table 1
        restart_row(9'd4);
        vaddr = 15'h34C6; patt_tbl = 1'b1;
        tick();
        check("mix_nt_addr", 32'(bus_if.bus_addr), 32'h24C6);
        tick(); tick();
        check("mix_at_addr", 32'(bus_if.bus_addr), 32'h27C9);
        tick(); tick();
        check("mix_lo_addr", 32'(bus_if.bus_addr), 32'h15A3);
        tick(); tick();
        check("mix_hi_addr", 32'(bus_if.bus_addr), 32'h15AB);
        tick(); tick();
        check("mix_record", {6'h0, tile_attr, tile_nt, tile_lo, tile_hi}, 32'h005A33CC);
        vaddr = 15'h0000; patt_tbl = 1'b0;

        // render_en dropped at dot 4: no tile, no reads; resumes next row
        restart_row(9'd6);
        for (int i = 0; i < 4; i++) tick();
        render_en = 1'b0;
        flag_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.bus_rd || tile_valid || h_inc) flag_a = 1'b1;
        end
        check("ren_drop_quiet", 32'(flag_a), 32'h0);
        check("ren_drop_keeps_tile", 32'(tile_nt), 32'h24);
        while (sl_col != 9'd0) tick();
        render_en = 1'b1;
        tick();
        check("ren_resume_col1", {bus_if.bus_rd, 17'h0, bus_if.bus_addr}, {1'b1, 17'h0, 14'h2000});
        for (int i = 0; i < 8; i++) tick();
        check("ren_resume_valid", 32'(tile_valid), 32'h1);

        // clk_en low in HI_A: state holds, pulses stay low
        restart_row(9'd8);
        for (int i = 0; i < 7; i++) tick();
        clk_en = 1'b0;
        flag_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_only();
            if (!bus_if.bus_rd || bus_if.bus_addr != 14'h0248 || tile_valid) flag_a = 1'b1;
        end
        check("clken_hold", 32'(flag_a), 32'h0);
        clk_en = 1'b1;
        tick(); tick();
        check("clken_resume", {23'h0, tile_valid, tile_hi}, {23'h0, 1'b1, 8'h0F});

        // Asynchronous reset mid-fetch at dot 5
        restart_row(9'd9);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_bus", {bus_if.bus_rd, 17'h0, bus_if.bus_addr}, 32'h0);
        check("midrst_tile", {tile_nt, tile_lo, tile_hi, 6'(tile_attr), tile_valid, h_inc},
              32'h0);
        #1;
        rst_n = 1'b1;
        flag_a = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (tile_valid) flag_a = 1'b1;
        end
        check("midrst_no_valid", 32'(flag_a), 32'h0);
        tick();
        check("midrst_realign_col17", 32'(tile_valid), 32'h1);

        // v_copy on the pre-render row: dots 280..304
        render_en = 1'b0; tick();
        sl_row = 9'h1FF; sl_col = 9'd270; render_en = 1'b1;
        n_vcopy = 0;
        for (int i = 0; i < 40; i++) begin tick(); n_vcopy += int'(v_copy); end
        check("prerender_v_copy_cnt", 32'(n_vcopy), 32'd25);

        // v_copy never on a visible row
        sl_row = 9'd5; sl_col = 9'd270;
        n_vcopy = 0;
        for (int i = 0; i < 40; i++) begin tick(); n_vcopy += int'(v_copy); end
        check("row5_v_copy_cnt", 32'(n_vcopy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
